// File: rtl/bus_data_interface_n.sv
// Four-phase handshake bus driver: captures one channel word, then runs setup/drive/hold/done on an active-low bus.
// Optional active-low odd-parity output is enabled by defining BDI_PARITY_EN.
module bus_data_interface_n #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned DRIVE_CYC = 4,
    parameter int unsigned HOLD_CYC  = 1,
    localparam int unsigned CSW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic [CSW-1:0]            chan_sel,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]          bus_l,
    output logic                      strobe,
    output logic                      busy,
    output logic                      ack
`ifdef BDI_PARITY_EN
    ,
    output logic                      parity_l
`endif
);

    typedef enum logic [2:0] {IDLE, SETUP, DRIVE, HOLD, DONE} state_t;

    // Counter reload values: each timed state lasts (load + 1) cycles.
    localparam logic [7:0] SETUP_LD = (SETUP_CYC > 0) ? 8'(SETUP_CYC - 1) : 8'd0;
    localparam logic [7:0] DRIVE_LD = (DRIVE_CYC > 0) ? 8'(DRIVE_CYC - 1) : 8'd0;
    localparam logic [7:0] HOLD_LD  = (HOLD_CYC > 0)  ? 8'(HOLD_CYC - 1)  : 8'd0;

    state_t           state;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] sel_word;

    // Out-of-range channel indices fall through to all-zeros.
    always_comb begin
        sel_word = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (chan_sel == CSW'(c))
                sel_word = data_in[c*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            word   <= '0;
            bus_l  <= '1;
            strobe <= 1'b0;
            busy   <= 1'b0;
            ack    <= 1'b0;
`ifdef BDI_PARITY_EN
            parity_l <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        word <= sel_word;
                        busy <= 1'b1;
                        if (SETUP_CYC != 0) begin
                            state <= SETUP;
                            cnt   <= SETUP_LD;
                        end else begin
                            state  <= DRIVE;
                            cnt    <= DRIVE_LD;
                            bus_l  <= ~sel_word;
                            strobe <= 1'b1;
`ifdef BDI_PARITY_EN
                            parity_l <= ~(^sel_word);
`endif
                        end
                    end
                end
                SETUP: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state  <= DRIVE;
                        cnt    <= DRIVE_LD;
                        bus_l  <= ~word;
                        strobe <= 1'b1;
`ifdef BDI_PARITY_EN
                        parity_l <= ~(^word);
`endif
                    end
                end
                DRIVE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        strobe <= 1'b0;
                        if (HOLD_CYC != 0) begin
                            state <= HOLD;
                            cnt   <= HOLD_LD;
                        end else begin
                            state <= DONE;
                            cnt   <= '0;
                            bus_l <= '1;
                            ack   <= 1'b1;
`ifdef BDI_PARITY_EN
                            parity_l <= 1'b1;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= DONE;
                        bus_l <= '1;
                        ack   <= 1'b1;
`ifdef BDI_PARITY_EN
                        parity_l <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    if (!req) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    bus_l  <= '1;
                    strobe <= 1'b0;
                    busy   <= 1'b0;
                    ack    <= 1'b0;
                end
            endcase
        end
    end

endmodule
